mux_lut_eval: RTL
=================

MUX_LUT_EVAL -- requirements
Module: mux_lut_eval

Interface
REQ-001 SHALL have parameter SEL_W, default 3, number of logic variables (legal 1..6); table depth TBL_D = 2**SEL_W.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port cfg_start, input, 1: start or restart a serial table load.
REQ-005 SHALL have port cfg_vld, input, 1: cfg_bit valid this cycle.
REQ-006 SHALL have port cfg_bit, input, 1: table bit, entry 0 first.
REQ-007 SHALL have port cfg_done, output, 1: one-cycle pulse when a new table is committed.
REQ-008 SHALL have port cfg_err, output, 1: one-cycle pulse when a load is rejected (see REQ-031).
REQ-009 SHALL have port in_vld, input, 1: variable vector valid.
REQ-010 SHALL have port in_sel, input, SEL_W: variable vector; MSB = first variable (A), LSB = last.
REQ-011 SHALL have port in_rdy, output, 1: a committed table exists and the pipeline can accept input.
REQ-012 SHALL have port out_vld, output, 1: out_l valid this cycle.
REQ-013 SHALL have port out_l, output, 1: evaluated function value.
REQ-014 SHALL have port loading, output, 1: high in LOAD and RELOAD states.

Function
REQ-015 SHALL hold two TBL_D-bit registers: shadow (being loaded) and active (used for evaluation).
REQ-016 SHALL implement FSM states EMPTY, LOAD, ACTIVE, RELOAD; EMPTY after reset.
REQ-017 EMPTY: cfg_start -> LOAD; in_rdy=0; in_vld ignored.
REQ-018 ACTIVE: cfg_start -> RELOAD; in_rdy=1.
REQ-019 LOAD/RELOAD: each cfg_vld cycle writes cfg_bit into shadow[bit_cnt] and increments bit_cnt (width SEL_W+1).
REQ-020 On the edge accepting bit TBL_D-1, active SHALL take shadow with that bit included; state -> ACTIVE; cfg_done pulses the following cycle.
REQ-021 cfg_start in LOAD/RELOAD SHALL clear bit_cnt and discard partial shadow; state is unchanged.
REQ-022 cfg_start and cfg_vld in the same cycle: cfg_start wins; the bit is ignored.
REQ-023 cfg_vld in EMPTY or ACTIVE SHALL be ignored.
REQ-024 RELOAD: in_rdy=1; evaluation continues using the old active table.
REQ-025 Input accepted when in_vld & in_rdy; stage 1 registers in_sel; stage 2 registers out_l = active[s1_sel] and out_vld=1.
REQ-026 Latency SHALL be exactly 2 cycles from accept edge to out_vld; throughput 1 per cycle; no output backpressure.
REQ-027 Stage-2 captures after the commit edge SHALL use the new table; captures at or before it SHALL use the old table.
REQ-028 out_vld SHALL be low when no sample is in stage 2; out_l holds its last value.

Reset
REQ-029 While rst_n=0: state=EMPTY, bit_cnt=0, shadow=0, active=0, pipeline valids=0, out_l=0, out_vld=0, cfg_done=0, cfg_err=0, in_rdy=0, loading=0.
REQ-030 Reset mid-load or mid-pipeline SHALL drop all in-flight data; no out_vld or cfg_done after release without new stimulus.

Configuration
REQ-031 With MUX_LUT_PARITY_EN defined: each load is TBL_D bits plus one even-parity bit (XOR of all table bits); commit occurs on the parity bit edge only if parity matches; on mismatch, active is unchanged, state returns to EMPTY (from LOAD) or ACTIVE (from RELOAD), and cfg_err pulses instead of cfg_done.
REQ-032 Without MUX_LUT_PARITY_EN: no parity bit; commit on bit TBL_D-1; cfg_err tied 0.

Verification (SEL_W=3, macro undefined unless stated)
REQ-033 Reset, then in_vld=1 with in_sel=3'b011 for 5 cycles -> in_rdy=0, out_vld never asserts.
REQ-034 cfg_start, then 8 bits 0,0,1,1,1,1,0,0 (table 0x3C) -> cfg_done pulses exactly one cycle after the 8th bit; in_sel 011, 010, 100, 111 back-to-back -> out_l 1, 1, 1, 0 on consecutive cycles starting 2 cycles after first accept.
REQ-035 In ACTIVE with 0x3C, reload 0xC3 while streaming in_sel=3'b011 every cycle -> out_l=1 up to the commit-edge result, 0 afterwards; in_rdy stays 1 throughout.
REQ-036 cfg_start after 5 bits, then 8 bits of 0xFF -> active=0xFF; the first 5 bits have no effect.
REQ-037 MUX_LUT_PARITY_EN: load 0x3C + parity 0 -> cfg_done; load 0x3C + parity 1 from EMPTY -> cfg_err, state EMPTY, in_rdy=0.
REQ-038 Assert rst_n=0 after 4 of 8 cfg bits with 2 samples in flight -> all outputs 0 immediately; no out_vld after release.

Source files
------------

// File: rtl/mux_lut_eval.sv
// Serially loaded SEL_W-input lookup table with a two-stage evaluation pipeline.
// Optional feature macro: MUX_LUT_PARITY_EN (adds an even-parity bit to every table load).
module mux_lut_eval #(
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_vld,
    input  logic             cfg_bit,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             in_vld,
    input  logic [SEL_W-1:0] in_sel,
    output logic             in_rdy,
    output logic             out_vld,
    output logic             out_l,
    output logic             loading
);

    localparam int unsigned TBL_D = 1 << SEL_W;
`ifdef MUX_LUT_PARITY_EN
    localparam int unsigned NUM_BITS = TBL_D + 1;
`else
    localparam int unsigned NUM_BITS = TBL_D;
`endif
    localparam logic [SEL_W:0] CNT_ONE = (SEL_W + 1)'(1);
    localparam logic [SEL_W:0] CNT_TBL = (SEL_W + 1)'(TBL_D);
    localparam logic [SEL_W:0] CNT_END = (SEL_W + 1)'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StActive,
        StReload
    } state_e;

    state_e             r_state;
    logic [SEL_W:0]     r_bit_cnt;
    logic [TBL_D-1:0]   r_shadow;
    logic [TBL_D-1:0]   r_active;
    logic               r_cfg_done;
    logic               r_cfg_err;
    logic               r_in_rdy;
    logic               r_loading;
    logic               r_s1_vld;
    logic [SEL_W-1:0]   r_s1_sel;
    logic               r_out_vld;
    logic               r_out_l;

    logic [TBL_D-1:0]   w_shadow_wr;
    logic               w_last;

    always_comb begin
        w_shadow_wr = r_shadow;
        if (r_bit_cnt < CNT_TBL) begin
            w_shadow_wr[r_bit_cnt[SEL_W-1:0]] = cfg_bit;
        end
    end

    assign w_last = (r_bit_cnt == CNT_END);

`ifdef MUX_LUT_PARITY_EN
    logic w_par_ok;
    assign w_par_ok = ((^r_shadow) == cfg_bit);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StEmpty;
            r_bit_cnt  <= '0;
            r_shadow   <= '0;
            r_active   <= '0;
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_in_rdy   <= 1'b0;
            r_loading  <= 1'b0;
        end else begin
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
            unique case (r_state)
                StEmpty: begin
                    if (cfg_start) begin
                        r_state   <= StLoad;
                        r_loading <= 1'b1;
                        r_bit_cnt <= '0;
                        r_shadow  <= '0;
                    end
                end
                StActive: begin
                    if (cfg_start) begin
                        r_state   <= StReload;
                        r_loading <= 1'b1;
                        r_bit_cnt <= '0;
                        r_shadow  <= '0;
                    end
                end
                StLoad, StReload: begin
                    // A restart wins over a simultaneous data bit.
                    if (cfg_start) begin
                        r_bit_cnt <= '0;
                        r_shadow  <= '0;
                    end else if (cfg_vld) begin
                        r_bit_cnt <= r_bit_cnt + CNT_ONE;
                        r_shadow  <= w_shadow_wr;
                        if (w_last) begin
                            r_bit_cnt <= '0;
                            r_loading <= 1'b0;
`ifdef MUX_LUT_PARITY_EN
                            if (w_par_ok) begin
                                r_active   <= r_shadow;
                                r_state    <= StActive;
                                r_in_rdy   <= 1'b1;
                                r_cfg_done <= 1'b1;
                            end else begin
                                r_cfg_err <= 1'b1;
                                r_state   <= (r_state == StLoad) ? StEmpty : StActive;
                            end
`else
                            r_active   <= w_shadow_wr;
                            r_state    <= StActive;
                            r_in_rdy   <= 1'b1;
                            r_cfg_done <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    r_state   <= StEmpty;
                    r_in_rdy  <= 1'b0;
                    r_loading <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2 reads r_active before any same-edge commit, so it sees the old table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_sel  <= '0;
            r_out_vld <= 1'b0;
            r_out_l   <= 1'b0;
        end else begin
            r_s1_vld <= in_vld & r_in_rdy;
            if (in_vld & r_in_rdy) begin
                r_s1_sel <= in_sel;
            end
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_l <= r_active[r_s1_sel];
            end
        end
    end

    assign cfg_done = r_cfg_done;
    assign cfg_err  = r_cfg_err;
    assign in_rdy   = r_in_rdy;
    assign loading  = r_loading;
    assign out_vld  = r_out_vld;
    assign out_l    = r_out_l;

endmodule
